uart_tx_ctrl: RTL

//  Transmit-side sequencer for the UART baud generator. Owns the divisor (dvsr) and baud_en,

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tick_cnt.sv | 40 ++++
 rtl/uart_tx_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sequencer states and default timing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int          DVSR_W        = 16;
    localparam int          OS_TICK_DEF   = 16;
    localparam int          STOP_TICK_DEF = 16;
    localparam logic [15:0] DVSR_DEF      = 16'd325;

endpackage

// File: rtl/uart_tick_cnt.sv
// Qualified baud-tick counter: hit pulses on the tick that reaches term (term = N-1).
// clr holds the count at zero; shared by the transmit and receive sequencers.
module uart_tick_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        hit   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == term) begin
                cnt_d = '0;
                hit   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: one frame per valid/ready handshake, owns the baud divisor
// and baud enable. All outputs registered; divisor writes during a frame are deferred.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int          DBIT      = 8,
    parameter int          OS_TICK   = OS_TICK_DEF,
    parameter int          STOP_TICK = STOP_TICK_DEF,
    parameter logic [15:0] DVSR_RST  = DVSR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DVSR_W-1:0] dvsr_wdata,
    input  logic              dvsr_wr,
    output logic [DVSR_W-1:0] dvsr,
    output logic              baud_en,
    input  logic              baud_tick,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic [DBIT-1:0]   tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int MAX_TICK = (OS_TICK > STOP_TICK) ? OS_TICK : STOP_TICK;
    localparam int CNT_W    = $clog2(MAX_TICK);
    localparam int BIT_W    = $clog2(DBIT);

    uart_state_e       state_q, state_d;
    logic [DBIT-1:0]   data_q, data_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              baud_en_q, baud_en_d;
    logic              done_q, done_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic [DVSR_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;

    logic             qtick;
    logic             hit;
    logic [CNT_W-1:0] term;
    logic             idle;
    logic             enter_idle;

    // A frozen generator can hold baud_tick high; only ticks while enabled count.
    assign qtick = baud_tick & baud_en_q;
    assign idle  = (state_q == IDLE);
    assign term  = (state_q == STOP) ? CNT_W'(STOP_TICK - 1) : CNT_W'(OS_TICK - 1);

    uart_tick_cnt #(
        .CNT_W (CNT_W)
    ) u_tick_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle),
        .tick (qtick),
        .term (term),
        .hit  (hit)
    );

    assign enter_idle = (state_q == STOP) && hit;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        baud_en_d  = baud_en_q;
        done_d     = 1'b0;
        dvsr_d     = dvsr_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d   = START;
                    data_d    = tx_data;
                    par_en_d  = parity_en;
                    par_bit_d = (^tx_data) ^ parity_odd;
                    tx_d      = 1'b0;
                    baud_en_d = 1'b1;
                end
            end
            START: begin
                if (hit) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = data_q[0];
                end
            end
            DATA: begin
                if (hit) begin
                    data_d = {1'b0, data_q[DBIT-1:1]};
                    if (bit_cnt_q == BIT_W'(DBIT - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = data_q[1];
                    end
                end
            end
            PARITY: begin
                if (hit) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (hit) begin
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    baud_en_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                tx_d      = 1'b1;
                baud_en_d = 1'b0;
            end
        endcase

        // The rate of a frame in flight never changes; deferred writes land on return to IDLE.
        if (enter_idle) begin
            dvsr_d     = dvsr_wr ? dvsr_wdata : (pend_vld_q ? pend_q : dvsr_q);
            pend_vld_d = 1'b0;
        end else if (dvsr_wr) begin
            if (idle && !tx_valid) begin
                dvsr_d = dvsr_wdata;
            end else begin
                pend_d     = dvsr_wdata;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            baud_en_q  <= 1'b0;
            done_q     <= 1'b0;
            dvsr_q     <= DVSR_RST;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            baud_en_q  <= baud_en_d;
            done_q     <= done_d;
            dvsr_q     <= dvsr_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign tx_ready = idle;
    assign busy     = !idle;
    assign tx       = tx_q;
    assign baud_en  = baud_en_q;
    assign tx_done  = done_q;
    assign dvsr     = dvsr_q;

endmodule
